ip_seq: RTL and testbench
=========================

# ip_seq

Registered instruction-pointer sequencer with an internal return stack and an optional interrupt entry path. It sits between instruction decode and instruction memory. Each cycle it selects the next IP from increment, immediate, TOS or return-stack top, and performs the call push or return pop itself. It drives both the combinational next address, for synchronous instruction RAM, and the registered current IP.

## Interface
- IADDR_WIDTH, 10, instruction address width.
- RS_DEPTH, 16, return-stack entries (≥2).
- RESET_VECTOR, 0, IP after reset.
- IRQ_VECTOR, 2, interrupt entry address (used only with IP_SEQ_IRQ_EN).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  hold IP and stack this cycle.
- TOS  in  IADDR_WIDTH  data-stack top (indirect target).
- TOS_is_zero  in  1  condition for ip_skip.
- ip_imm  in  IADDR_WIDTH  immediate target.
- ip_skip  in  1  conditional branch; not taken when TOS nonzero.
- ip_imm_sel  in  1  target = ip_imm.
- ip_tos_sel  in  1  target = TOS.
- ip_call  in  1  with imm/tos select: push IP+1.
- ip_ret  in  1  target = stack top, pop.
- err_clr  in  1  clear sticky error flags.
- irq_req  in  1  level interrupt request.
- irq_ack  out  1  one-cycle pulse, interrupt taken.
- ip  out  IADDR_WIDTH  current IP (registered).
- ip_next  out  IADDR_WIDTH  next IP (combinational).
- rs_top  out  IADDR_WIDTH  return-stack top; 0 when empty.
- rs_depth  out  clog2(RS_DEPTH+1)  entries in use.
- rs_overflow, rs_underflow  out  1 each  sticky errors.

## Operation
- Priority, first match wins:
  1. stall: ip_next = ip; no push or pop.
  2. IRQ take: irq_req && !irq_active. Push ip, the interrupted instruction, which is re-executed. ip_next = IRQ_VECTOR. Decode inputs are ignored this cycle.
  3. ip_skip && !TOS_is_zero: ip+1.
  4. ip_ret: rs_top, pop.
  5. ip_imm_sel: ip_imm, push ip+1 if ip_call.
  6. ip_tos_sel: TOS, push ip+1 if ip_call.
  7. Otherwise: ip+1.
- ip_skip with TOS zero falls through to rules 4–7.
- ip+1 wraps modulo 2^IADDR_WIDTH; max address goes to 0.
- ip_call without an imm or tos select is ignored.
- Push when full: the push is dropped, depth is unchanged, rs_overflow is set, and the jump is still taken.
- Pop when empty: ip_next = ip+1, depth stays 0, rs_underflow is set.
- err_clr clears both flags. A new error in the same cycle wins, so the flag stays set.
- irq_active is set on take, and irq_depth records the pre-push depth.
- irq_active clears on the ret whose pop returns depth to irq_depth. Interrupts are not nested.
- If a take's push overflows, it is still taken and rs_overflow is set.

## Timing
- Reset values:
  - ip = RESET_VECTOR; ip_next follows the current inputs.
  - rs_depth = 0, rs_top = 0.
  - rs_overflow = 0, rs_underflow = 0.
  - irq_active = 0, irq_ack = 0.
- ip, stack, depth and flags update on the clk edge that ends the decision cycle. ip_next is valid in the same cycle as its inputs, so IP has 1-cycle latency.
- irq_ack is registered: high in the cycle after the take, for exactly 1 cycle. A request still held during that cycle is not retaken.
- A push or pop makes rs_top and rs_depth reflect the new stack in the next cycle.
- Reset mid-operation empties the stack and drops irq_active immediately.

## Configuration
- IP_SEQ_IRQ_EN defined: rule 2, irq_active, irq_depth and irq_ack are present.
- Not defined: irq_req is ignored, irq_ack is tied 0, and no IRQ state is built. Behaviour is otherwise identical.

## Structure
- Package ip_seq_pkg:
  - Next-source enum: SRC_HOLD, SRC_IRQ, SRC_INC, SRC_RET, SRC_IMM, SRC_TOS.
  - Depth-width helper function.
- Sub-module ip_rstack: LIFO register array with push/pop/full/empty, top and depth. It flags overflow and underflow. The sequencer owns the select logic.

## Test plan
- Reset with RESET_VECTOR=0x010, then 3 idle cycles → ip 0x010, 0x011, 0x012, 0x013; depth 0.
- At ip=0x020: call imm 0x100, then ret → ip 0x100, rs_top 0x021, depth 1; then ip 0x021, depth 0.
- ip_skip at ip=0x3FF with TOS=5 → ip 0x000 (wrap). ip_skip with TOS=0 and ip_imm_sel=1, ip_imm 0x040 → ip 0x040.
- 17 calls with RS_DEPTH=16 → depth 16, rs_overflow=1. 17 rets → the 17th gives rs_underflow=1, ip=previous+1. err_clr clears both flags.
- stall during a call → ip and depth unchanged; the call completes on the first unstalled cycle.
- IRQ_EN: at ip=0x050 with depth 2, irq_req held high →
  - ip = IRQ_VECTOR; irq_ack pulses once; depth 3.
  - A ret restores ip 0x050 and clears irq_active.
  - The still-high irq_req is then retaken.

Source files
------------

// File: rtl/ip_seq_pkg.sv
// Shared types and helpers for the instruction-pointer sequencer.
package ip_seq_pkg;

    // Where the next IP comes from this cycle
    typedef enum logic [2:0] {
        SRC_HOLD = 3'd0,
        SRC_IRQ  = 3'd1,
        SRC_INC  = 3'd2,
        SRC_RET  = 3'd3,
        SRC_IMM  = 3'd4,
        SRC_TOS  = 3'd5
    } src_e;

    // Bits needed to count 0..n inclusive
    function automatic int depth_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ip_seq_rstack.sv
// Return stack: LIFO register array with sticky overflow/underflow flags.
// A push when full is dropped; a pop when empty leaves the stack untouched.
module ip_rstack
    import ip_seq_pkg::*;
#(
    parameter int AW    = 10,
    parameter int DEPTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  logic [AW-1:0]             i_din,
    input  logic                      i_err_clr,
    output logic [AW-1:0]             o_top,
    output logic [depth_w(DEPTH)-1:0] o_depth,
    output logic                      o_empty,
    output logic                      o_overflow,
    output logic                      o_underflow
);
    localparam int DW = depth_w(DEPTH);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_depth;
    logic          r_ovf;
    logic          r_unf;
    logic          w_full;
    logic [IW-1:0] w_top_idx;

    assign w_full      = (r_depth == DW'(DEPTH));
    assign o_empty     = (r_depth == '0);
    assign w_top_idx   = IW'(r_depth - 1'b1);
    assign o_top       = o_empty ? '0 : r_mem[w_top_idx];
    assign o_depth     = r_depth;
    assign o_overflow  = r_ovf;
    assign o_underflow = r_unf;

    // Entry storage; contents beyond depth are don't-care so no reset needed
    always_ff @(posedge i_clk) begin
        if (i_push && !w_full)
            r_mem[r_depth[IW-1:0]] <= i_din;
    end

    // Depth counter and sticky error flags (a fresh error beats a clear)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (i_push && !w_full)
                r_depth <= r_depth + 1'b1;
            else if (i_pop && !o_empty)
                r_depth <= r_depth - 1'b1;
            r_ovf <= (i_push && w_full)  || (r_ovf && !i_err_clr);
            r_unf <= (i_pop  && o_empty) || (r_unf && !i_err_clr);
        end
    end

endmodule

// File: rtl/ip_seq.sv
// Instruction-pointer sequencer with return stack.
// Define IP_SEQ_IRQ_EN to build the interrupt entry path (take, ack, nesting guard).
module ip_seq
    import ip_seq_pkg::*;
#(
    parameter int                     IADDR_WIDTH  = 10,
    parameter int                     RS_DEPTH     = 16,
    parameter logic [IADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [IADDR_WIDTH-1:0] IRQ_VECTOR   = IADDR_WIDTH'(2)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic [IADDR_WIDTH-1:0]       TOS,
    input  logic                         TOS_is_zero,
    input  logic [IADDR_WIDTH-1:0]       ip_imm,
    input  logic                         ip_skip,
    input  logic                         ip_imm_sel,
    input  logic                         ip_tos_sel,
    input  logic                         ip_call,
    input  logic                         ip_ret,
    input  logic                         err_clr,
    input  logic                         irq_req,
    output logic                         irq_ack,
    output logic [IADDR_WIDTH-1:0]       ip,
    output logic [IADDR_WIDTH-1:0]       ip_next,
    output logic [IADDR_WIDTH-1:0]       rs_top,
    output logic [depth_w(RS_DEPTH)-1:0] rs_depth,
    output logic                         rs_overflow,
    output logic                         rs_underflow
);
    localparam int DW = depth_w(RS_DEPTH);

    logic [IADDR_WIDTH-1:0] r_ip;
    logic [IADDR_WIDTH-1:0] w_inc;
    logic [IADDR_WIDTH-1:0] w_next;
    logic [IADDR_WIDTH-1:0] w_push_data;
    logic [DW-1:0]          w_depth;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_take;
    src_e                   w_src;

    assign w_inc = r_ip + 1'b1;

`ifdef IP_SEQ_IRQ_EN
    logic          r_irq_active;
    logic          r_irq_ack;
    logic [DW-1:0] r_irq_depth;

    assign w_take  = irq_req && !r_irq_active;
    assign irq_ack = r_irq_ack;

    // Interrupt bookkeeping: remember pre-push depth, leave on the matching return
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_active <= 1'b0;
            r_irq_ack    <= 1'b0;
            r_irq_depth  <= '0;
        end else begin
            r_irq_ack <= (w_src == SRC_IRQ);
            if (w_src == SRC_IRQ) begin
                r_irq_active <= 1'b1;
                r_irq_depth  <= w_depth;
            end else if (w_src == SRC_RET && !w_empty &&
                         DW'(w_depth - 1'b1) == r_irq_depth) begin
                r_irq_active <= 1'b0;
            end
        end
    end
`else
    logic w_unused;
    assign w_unused = irq_req ^ (^IRQ_VECTOR);
    assign w_take   = 1'b0;
    assign irq_ack  = 1'b0;
`endif

    // Priority decode of the next-IP source
    always_comb begin
        w_src = SRC_INC;
        if (stall)                       w_src = SRC_HOLD;
        else if (w_take)                 w_src = SRC_IRQ;
        else if (ip_skip && !TOS_is_zero) w_src = SRC_INC;
        else if (ip_ret)                 w_src = SRC_RET;
        else if (ip_imm_sel)             w_src = SRC_IMM;
        else if (ip_tos_sel)             w_src = SRC_TOS;
    end

    // Next-IP mux plus stack command; a return on empty just advances
    always_comb begin
        w_next      = w_inc;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_push_data = w_inc;
        case (w_src)
            SRC_HOLD: w_next = r_ip;
            SRC_IRQ: begin
                w_next      = IRQ_VECTOR;
                w_push      = 1'b1;
                w_push_data = r_ip;
            end
            SRC_RET: begin
                w_next = w_empty ? w_inc : rs_top;
                w_pop  = 1'b1;
            end
            SRC_IMM: begin
                w_next = ip_imm;
                w_push = ip_call;
            end
            SRC_TOS: begin
                w_next = TOS;
                w_push = ip_call;
            end
            default: w_next = w_inc;
        endcase
    end

    // Current IP register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_ip <= RESET_VECTOR;
        else       r_ip <= w_next;
    end

    ip_rstack #(.AW(IADDR_WIDTH), .DEPTH(RS_DEPTH)) u_rstack (
        .i_clk       (clk),
        .i_rst       (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_din       (w_push_data),
        .i_err_clr   (err_clr),
        .o_top       (rs_top),
        .o_depth     (w_depth),
        .o_empty     (w_empty),
        .o_overflow  (rs_overflow),
        .o_underflow (rs_underflow)
    );

    assign ip       = r_ip;
    assign ip_next  = w_next;
    assign rs_depth = w_depth;

endmodule

// File: tb/tb_ip_seq.sv
// Scoreboard bench for ip_seq: a queue-based reference model predicts each cycle.
module tb_ip_seq;
    import ip_seq_pkg::*;

    localparam int AW   = 10;
    localparam int RSD  = 16;
    localparam int DW   = depth_w(RSD);
    localparam int RV   = 'h010;
    localparam int IV   = 2;
    localparam int MASK = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall, TOS_is_zero, ip_skip, ip_imm_sel, ip_tos_sel;
    logic          ip_call, ip_ret, err_clr, irq_req, irq_ack;
    logic [AW-1:0] TOS, ip_imm, ip, ip_next, rs_top;
    logic [DW-1:0] rs_depth;
    logic          rs_overflow, rs_underflow;

    always #5 clk = ~clk;

    ip_seq #(.IADDR_WIDTH(AW), .RS_DEPTH(RSD), .RESET_VECTOR(10'h010),
             .IRQ_VECTOR(10'h002)) dut (
        .clk(clk), .reset(reset), .stall(stall), .TOS(TOS),
        .TOS_is_zero(TOS_is_zero), .ip_imm(ip_imm), .ip_skip(ip_skip),
        .ip_imm_sel(ip_imm_sel), .ip_tos_sel(ip_tos_sel), .ip_call(ip_call),
        .ip_ret(ip_ret), .err_clr(err_clr), .irq_req(irq_req), .irq_ack(irq_ack),
        .ip(ip), .ip_next(ip_next), .rs_top(rs_top), .rs_depth(rs_depth),
        .rs_overflow(rs_overflow), .rs_underflow(rs_underflow)
    );

    typedef struct { int ip; int depth; int top; bit ovf; bit uf; bit ack; } exp_t;
    typedef struct { bit stall; bit irq; bit skip; bit tz; bit ret; bit imm_sel;
                     bit tos_sel; bit call; bit clr; int imm; int tos; } stim_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    int   m_ip;
    int   m_stk[$];
    int   m_irqd;
    bit   m_ovf, m_uf, m_act, m_ack;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ip = RV; m_stk.delete(); m_irqd = 0;
        m_ovf = 0; m_uf = 0; m_act = 0; m_ack = 0;
    endtask

    function automatic stim_t s_idle();
        stim_t s = '{default: 0};
        return s;
    endfunction

    // Drive one cycle, predict it, check ip_next now and registered state after the edge
    task automatic apply(input stim_t s);
        int nip, inc, pdata;
        bit push, pop, take, eo, eu;
        exp_t e;
        stall = s.stall; irq_req = s.irq; ip_skip = s.skip; TOS_is_zero = s.tz;
        ip_ret = s.ret; ip_imm_sel = s.imm_sel; ip_tos_sel = s.tos_sel;
        ip_call = s.call; err_clr = s.clr; ip_imm = AW'(s.imm); TOS = AW'(s.tos);
        inc = (m_ip + 1) & MASK;
        push = 0; pop = 0; take = 0; eo = 0; eu = 0; pdata = inc;
        if (s.stall) nip = m_ip;
`ifdef IP_SEQ_IRQ_EN
        else if (s.irq && !m_act) begin nip = IV; push = 1; pdata = m_ip; take = 1; end
`endif
        else if (s.skip && !s.tz) nip = inc;
        else if (s.ret) begin
            if (m_stk.size() == 0) begin nip = inc; eu = 1; end
            else begin nip = m_stk[$]; pop = 1; end
        end
        else if (s.imm_sel) begin nip = s.imm & MASK; push = s.call; end
        else if (s.tos_sel) begin nip = s.tos & MASK; push = s.call; end
        else nip = inc;
        if (take) begin m_act = 1; m_irqd = m_stk.size(); end
        if (push) begin
            if (m_stk.size() == RSD) eo = 1;
            else m_stk.push_back(pdata);
        end
        if (pop) begin
            pdata = m_stk.pop_back();
            if (m_act && m_stk.size() == m_irqd) m_act = 0;
        end
        m_ovf = eo | (m_ovf & !s.clr);
        m_uf  = eu | (m_uf & !s.clr);
        m_ack = take;
        m_ip  = nip;
        sb.push_back('{m_ip, m_stk.size(), (m_stk.size() != 0) ? m_stk[$] : 0,
                       m_ovf, m_uf, m_ack});
        #1 chk("ip_next", 32'(ip_next), nip);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk("ip", 32'(ip), e.ip);
        chk("rs_depth", 32'(rs_depth), e.depth);
        chk("rs_top", 32'(rs_top), e.top);
        chk("rs_overflow", 32'(rs_overflow), 32'(e.ovf));
        chk("rs_underflow", 32'(rs_underflow), 32'(e.uf));
        chk("irq_ack", 32'(irq_ack), 32'(e.ack));
    endtask

    task automatic jmp(input int a, input bit call);
        stim_t s = s_idle();
        s.imm_sel = 1; s.imm = a; s.call = call;
        apply(s);
    endtask

    task automatic ret1(input bit clr);
        stim_t s = s_idle();
        s.ret = 1; s.clr = clr;
        apply(s);
    endtask

    initial begin
        stim_t s;
        reset = 1'b1;
        s = s_idle();
        stall = 0; irq_req = 0; ip_skip = 0; TOS_is_zero = 0; ip_ret = 0;
        ip_imm_sel = 0; ip_tos_sel = 0; ip_call = 0; err_clr = 0; ip_imm = '0; TOS = '0;
        #12;
        chk("rst_ip", 32'(ip), RV);
        chk("rst_depth", 32'(rs_depth), 0);
        chk("rst_top", 32'(rs_top), 0);
        chk("rst_flags", {30'd0, rs_overflow, rs_underflow}, 0);
        chk("rst_ack", 32'(irq_ack), 0);
        reset = 1'b0;
        model_reset();

        // idle increment
        repeat (3) apply(s_idle());
        chk("idle_ip", 32'(ip), 'h013);

        // call / return
        jmp('h020, 0);
        jmp('h100, 1);
        chk("call_ip", 32'(ip), 'h100);
        chk("call_top", 32'(rs_top), 'h021);
        ret1(0);
        chk("ret_ip", 32'(ip), 'h021);
        chk("ret_depth", 32'(rs_depth), 0);

        // skip taken with wrap, skip not taken falls through to imm
        jmp('h3FF, 0);
        s = s_idle(); s.skip = 1; s.tos = 5; s.imm_sel = 1; s.imm = 'h155;
        apply(s);
        chk("skip_wrap", 32'(ip), 0);
        s = s_idle(); s.skip = 1; s.tz = 1; s.imm_sel = 1; s.imm = 'h040;
        apply(s);
        chk("skip_fall", 32'(ip), 'h040);

        // bare call ignored, TOS call
        s = s_idle(); s.call = 1; apply(s);
        s = s_idle(); s.tos_sel = 1; s.tos = 'h123; s.call = 1; apply(s);
        chk("tos_call_top", 32'(rs_top), 'h042);
        ret1(0);

        // overflow then underflow, then clear
        repeat (17) jmp('h200, 1);
        chk("ovf_depth", 32'(rs_depth), 16);
        chk("ovf_flag", 32'(rs_overflow), 1);
        repeat (17) ret1(0);
        chk("unf_flag", 32'(rs_underflow), 1);
        chk("unf_ip", 32'(ip), 'h044);
        ret1(1);
        chk("clr_vs_err", 32'(rs_underflow), 1);
        s = s_idle(); s.clr = 1; apply(s);
        chk("clr_flags", {30'd0, rs_overflow, rs_underflow}, 0);

        // stalled call holds, completes when released
        s = s_idle(); s.imm_sel = 1; s.imm = 'h300; s.call = 1; s.stall = 1;
        apply(s);
        chk("stall_depth", 32'(rs_depth), 0);
        s.stall = 0;
        apply(s);
        chk("unstall_ip", 32'(ip), 'h300);

        // asynchronous reset mid-operation
        jmp('h310, 1);
        reset = 1'b1;
        #1;
        chk("arst_depth", 32'(rs_depth), 0);
        chk("arst_ip", 32'(ip), RV);
        reset = 1'b0;
        model_reset();

`ifdef IP_SEQ_IRQ_EN
        jmp('h040, 1);
        jmp('h050, 1);
        s = s_idle(); s.irq = 1;
        apply(s);
        chk("irq_ip", 32'(ip), IV);
        chk("irq_depth", 32'(rs_depth), 3);
        apply(s);
        chk("irq_ack_pulse", 32'(irq_ack), 1);
        s.ret = 1;
        apply(s);
        chk("irq_ret_ip", 32'(ip), 'h050);
        s.ret = 0;
        apply(s);
        chk("irq_retake", 32'(ip), IV);
        ret1(0);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            s = s_idle();
            s.stall   = ($urandom_range(7) == 0);
            s.irq     = ($urandom_range(5) == 0);
            s.skip    = ($urandom_range(3) == 0);
            s.tz      = $urandom_range(1);
            s.ret     = ($urandom_range(3) == 0);
            s.imm_sel = ($urandom_range(2) == 0);
            s.tos_sel = ($urandom_range(2) == 0);
            s.call    = $urandom_range(1);
            s.clr     = ($urandom_range(15) == 0);
            s.imm     = $urandom_range(MASK);
            s.tos     = $urandom_range(MASK);
            apply(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
